// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS-subset controller
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC     = 4'd2,
        ST_WB       = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_LW_WB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_TRAP     = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU_R = 4'd0,
        CLS_JR    = 4'd1,
        CLS_ADDI  = 4'd2,
        CLS_XORI  = 4'd3,
        CLS_LW    = 4'd4,
        CLS_SW    = 4'd5,
        CLS_BNE   = 4'd6,
        CLS_J     = 4'd7,
        CLS_JAL   = 4'd8,
        CLS_NONE  = 4'd9
    } instr_class_e;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_SIMM = 2'd1;
    localparam logic [1:0] SRC_B_ZIMM = 2'd2;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_OPCODE  = 2'd1;
    localparam logic [1:0] FAULT_FUNCT   = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    typedef struct packed {
        instr_class_e cls;
        logic         op_legal;
        logic         funct_legal;
        logic [1:0]   r_alu_op;
    } decode_t;

endpackage

// File: rtl/mips_main_decode.sv
// rtl/mips_main_decode.sv - opcode/funct to instruction class and legality flags
module mips_main_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output decode_t    dec_o
);

    // Classify the held instruction; funct only matters for R-type.
    always_comb begin
        dec_o.cls         = CLS_NONE;
        dec_o.op_legal    = 1'b1;
        dec_o.funct_legal = 1'b1;
        dec_o.r_alu_op    = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  begin dec_o.cls = CLS_ALU_R; dec_o.r_alu_op = ALU_ADD; end
                    FN_SUB:  begin dec_o.cls = CLS_ALU_R; dec_o.r_alu_op = ALU_SUB; end
                    FN_SLT:  begin dec_o.cls = CLS_ALU_R; dec_o.r_alu_op = ALU_SLT; end
                    FN_JR:   dec_o.cls = CLS_JR;
                    default: dec_o.funct_legal = 1'b0;
                endcase
            end
            OP_ADDI: dec_o.cls = CLS_ADDI;
            OP_XORI: dec_o.cls = CLS_XORI;
            OP_LW:   dec_o.cls = CLS_LW;
            OP_SW:   dec_o.cls = CLS_SW;
            OP_BNE:  dec_o.cls = CLS_BNE;
            OP_J:    dec_o.cls = CLS_J;
            OP_JAL:  dec_o.cls = CLS_JAL;
            default: dec_o.op_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - sequencing controller for the multi-cycle MIPS-subset CPU
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       mem_re,
    output logic       mem_we,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] fault,
    output logic [3:0] state
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] wait_inc;
    logic             timed_out;
    decode_t          dec;

    mips_main_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .dec_o    (dec)
    );

    // A timeout of zero disables both counting and the fault; a late mem_ready
    // still wins because the ready branch is tested before timed_out.
    assign wait_inc  = (MEM_TIMEOUT != 0) ? (wait_q + CNT_W'(1)) : '0;
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_C);

    // State, sticky fault and memory wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, fault capture and wait counting (counter clears whenever not waiting).
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        wait_d  = '0;
        case (state_q)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ready) begin
                    case (state_q)
                        ST_FETCH:  state_d = ST_DECODE;
                        ST_MEM_RD: state_d = ST_LW_WB;
                        default:   state_d = ST_FETCH;
                    endcase
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_DECODE: begin
                if (!dec.op_legal) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_OPCODE;
                end else if (!dec.funct_legal) begin
                    state_d = ST_TRAP;
                    fault_d = FAULT_FUNCT;
                end else begin
                    case (dec.cls)
                        CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                        CLS_BNE:        state_d = ST_BRANCH;
                        CLS_J, CLS_JAL: state_d = ST_JUMP;
                        default:        state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC:     state_d = (dec.cls == CLS_JR) ? ST_FETCH : ST_WB;
            ST_MEM_ADDR: state_d = (dec.cls == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; FETCH and BRANCH enables follow mem_ready/zero in the same cycle.
    // Everything is forced low during reset so an aborted instruction writes nothing.
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        alu_src_b = SRC_B_RT;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        reg_dst   = REG_DST_RT;
        wb_sel    = WB_ALU;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_re = 1'b1;
                    ir_we  = mem_ready;
                    pc_we  = mem_ready;
                end
                ST_EXEC: begin
                    case (dec.cls)
                        CLS_JR: begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_REG;
                        end
                        CLS_ADDI: begin
                            alu_src_b = SRC_B_SIMM;
                            alu_op    = ALU_ADD;
                        end
                        CLS_XORI: begin
                            alu_src_b = SRC_B_ZIMM;
                            alu_op    = ALU_XOR;
                        end
                        default: begin
                            alu_src_b = SRC_B_RT;
                            alu_op    = dec.r_alu_op;
                        end
                    endcase
                end
                ST_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = WB_ALU;
                    reg_dst = (dec.cls == CLS_ALU_R) ? REG_DST_RD : REG_DST_RT;
                end
                ST_MEM_ADDR: begin
                    alu_src_b = SRC_B_SIMM;
                    alu_op    = ALU_ADD;
                end
                ST_MEM_RD: mem_re = 1'b1;
                ST_MEM_WR: mem_we = 1'b1;
                ST_LW_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = WB_MEM;
                    reg_dst = REG_DST_RT;
                end
                ST_BRANCH: begin
                    alu_src_b = SRC_B_RT;
                    alu_op    = ALU_SUB;
                    pc_we     = ~zero;
                    pc_src    = PC_SRC_BRANCH;
                end
                ST_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                    if (dec.cls == CLS_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = REG_DST_R31;
                        wb_sel  = WB_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       ir_we, pc_we, mem_re, mem_we, reg_we;
    logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, wb_sel, fault;
    logic [3:0] state;
    logic [20:0] obs;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic        z;
        logic [20:0] exp;
    } step_t;

    step_t q[$];
    logic [5:0] cur_op, cur_fn;
    string      cur_tag;

    localparam logic [20:0] EN_MASK = 21'h1FFFC0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .fault     (fault),
        .state     (state)
    );

    assign obs = {ir_we, pc_we, pc_src, mem_re, mem_we, alu_src_b, alu_op,
                  reg_we, reg_dst, wb_sel, fault, state};

    function automatic logic [20:0] vec(input int st, input int ir, input int pw, input int ps,
                                        input int mre, input int mwe, input int asb, input int aop,
                                        input int rwe, input int rdst, input int wbs, input int flt);
        vec = {ir[0], pw[0], ps[1:0], mre[0], mwe[0], asb[1:0], aop[1:0],
               rwe[0], rdst[1:0], wbs[1:0], flt[1:0], st[3:0]};
    endfunction

    function automatic logic rb();
        rb = 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        legal_op = (op == 6'd0) || (op == 6'd8) || (op == 6'd14) || (op == 6'd35) ||
                   (op == 6'd43) || (op == 6'd5) || (op == 6'd2) || (op == 6'd3);
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        legal_fn = (fn == 6'd32) || (fn == 6'd34) || (fn == 6'd42) || (fn == 6'd8);
    endfunction

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic mr, input logic z, input logic [20:0] e);
        q.push_back({cur_op, cur_fn, mr, z, e});
    endtask

    // Instruction index: 0 ADD 1 SUB 2 SLT 3 JR 4 ADDI 5 XORI 6 LW 7 SW 8 BNE 9 J 10 JAL
    task automatic set_instr(input int k);
        logic [5:0] ops [11] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd14, 6'd35, 6'd43, 6'd5, 6'd2, 6'd3};
        logic [5:0] fns [4]  = '{6'd32, 6'd34, 6'd42, 6'd8};
        cur_op = ops[k];
        cur_fn = (k < 4) ? fns[k] : 6'($urandom_range(0, 63));
    endtask

    task automatic model_fetch(input int fs);
        for (int i = 0; i < fs; i++) push(1'b0, rb(), vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(1'b1, rb(), vec(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(rb(), rb(), vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Expected per-cycle outputs of one instruction, fs fetch stalls, ms memory stalls.
    task automatic model_instr(input int k, input int fs, input int ms, input logic z);
        set_instr(k);
        model_fetch(fs);
        case (k)
            0, 1, 2: begin
                push(rb(), rb(), vec(2, 0, 0, 0, 0, 0, 0, (k == 0) ? 0 : (k == 1) ? 1 : 3, 0, 0, 0, 0));
                push(rb(), rb(), vec(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
            end
            3: push(rb(), rb(), vec(2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
            4, 5: begin
                push(rb(), rb(), vec(2, 0, 0, 0, 0, 0, (k == 4) ? 1 : 2, (k == 4) ? 0 : 2, 0, 0, 0, 0));
                push(rb(), rb(), vec(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            6: begin
                push(rb(), rb(), vec(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
                for (int i = 0; i < ms; i++) push(1'b0, rb(), vec(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                push(1'b1, rb(), vec(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                push(rb(), rb(), vec(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            end
            7: begin
                push(rb(), rb(), vec(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
                for (int i = 0; i < ms; i++) push(1'b0, rb(), vec(6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
                push(1'b1, rb(), vec(6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            8:  push(rb(), z, vec(8, 0, z ? 0 : 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
            9:  push(rb(), rb(), vec(9, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
            default: push(rb(), rb(), vec(9, 0, 1, 2, 0, 0, 0, 0, 1, 2, 2, 0));
        endcase
    endtask

    task automatic model_trap(input int flt);
        for (int i = 0; i < 3; i++) push(rb(), rb(), vec(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, flt));
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            opcode    = s.op;
            funct     = s.fn;
            mem_ready = s.mr;
            zero      = s.z;
            #1;
            chk(cur_tag, obs, s.exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = rb();
        #1;
        chk({tag, "_reset_cycle"}, obs & EN_MASK, 21'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk({tag, "_after_reset"}, obs, vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", obs, 21'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_fetch", obs, vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        cur_tag = "add";      model_instr(0, 0, 0, 1'b0); run_q();
        cur_tag = "lw_stall"; model_instr(6, 0, 3, 1'b0); run_q();
        cur_tag = "bne_z1";   model_instr(8, 0, 0, 1'b1); run_q();
        cur_tag = "bne_z0";   model_instr(8, 0, 0, 1'b0); run_q();
        cur_tag = "jal";      model_instr(10, 0, 0, 1'b0); run_q();
        cur_tag = "jr";       model_instr(3, 0, 0, 1'b0); run_q();

        cur_tag = "random";
        for (int n = 0; n < 40; n++) begin
            model_instr($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run_q();
        end

        cur_tag = "fetch_ready_at_limit"; model_instr(4, 16, 0, 1'b0); run_q();
        cur_tag = "mem_ready_at_limit";   model_instr(6, 0, 16, 1'b0); run_q();

        cur_tag = "sw_abort";
        set_instr(7);
        model_fetch(0);
        push(rb(), rb(), vec(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        push(1'b0, rb(), vec(6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run_q();
        do_reset("sw_abort");

        cur_tag = "bad_opcode";
        cur_op = 6'b111111; cur_fn = 6'($urandom_range(0, 63));
        model_fetch(0); model_trap(1); run_q();
        do_reset("bad_opcode");

        cur_tag = "bad_funct";
        cur_op = 6'b000000; cur_fn = 6'b000001;
        model_fetch(0); model_trap(2); run_q();
        do_reset("bad_funct");

        cur_tag = "rand_illegal";
        for (int n = 0; n < 6; n++) begin
            if (n < 3) begin
                do cur_op = 6'($urandom_range(0, 63)); while (legal_op(cur_op));
                cur_fn = 6'($urandom_range(0, 63));
            end else begin
                cur_op = 6'd0;
                do cur_fn = 6'($urandom_range(0, 63)); while (legal_fn(cur_fn));
            end
            model_fetch(0); model_trap((n < 3) ? 1 : 2); run_q();
            do_reset("rand_illegal");
        end

        cur_tag = "pre_timeout"; model_instr(0, 0, 0, 1'b0); run_q();
        cur_tag = "timeout";
        for (int i = 0; i < 17; i++) push(1'b0, rb(), vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        model_trap(3);
        run_q();
        do_reset("timeout");

        cur_tag = "final_j"; model_instr(9, 1, 0, 1'b0); run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
